alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu.sv | 29 ++
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its two-requester arbiter:
// data width, opcode constants and the arbiter FSM state type.
package alu_pkg;

   localparam int ALU_W = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_NOT = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // Opcodes 101-111 are reserved and flagged as errors.
   function automatic logic op_is_legal(input logic [2:0] op);
      return (op <= OP_NOT);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters plus one consumer (master)
// and the alu_arbiter (slave).
interface alu_arbiter_if;
   import alu_pkg::*;

   logic             req0_valid;
   logic             req0_ready;
   logic [ALU_W-1:0] req0_a;
   logic [ALU_W-1:0] req0_b;
   logic [2:0]       req0_op;

   logic             req1_valid;
   logic             req1_ready;
   logic [ALU_W-1:0] req1_a;
   logic [ALU_W-1:0] req1_b;
   logic [2:0]       req1_op;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [ALU_W-1:0] rsp_result;
   logic             rsp_carry;
   logic             rsp_err;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err,
      input  rsp_ready
   );

endinterface

// File: rtl/alu.sv
// Shared combinational 4-bit ALU; carry is the add carry-out or the subtract borrow.
module alu
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic [2:0]       op,
   output logic [ALU_W-1:0] result,
   output logic             carry
);

   logic [ALU_W:0] wide;

   always_comb begin
      wide = '0;
      case (op)
         OP_ADD:  wide = {1'b0, a} + {1'b0, b};
         OP_SUB:  wide = {1'b0, a} - {1'b0, b};
         OP_AND:  wide = {1'b0, a & b};
         OP_OR:   wide = {1'b0, a | b};
         OP_NOT:  wide = {1'b0, ~a};
         default: wide = '0;
      endcase
   end

   assign result = wide[ALU_W-1:0];
   assign carry  = wide[ALU_W];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared alu: IDLE grants one request, EXEC runs it,
// RESP holds the result. Define ALU_ARB_ROUND_ROBIN_EN for round robin, else req0 wins.
module alu_arbiter
   import alu_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);

   arb_state_t       state;
   logic [ALU_W-1:0] cap_a;
   logic [ALU_W-1:0] cap_b;
   logic [2:0]       cap_op;
   logic             cap_id;

   logic             grant0;
   logic             grant1;
   logic [ALU_W-1:0] alu_result;
   logic             alu_carry;

   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [ALU_W-1:0] rsp_result_q;
   logic             rsp_carry_q;
   logic             rsp_err_q;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   // Requester that wins the next tie: 0 = req0, 1 = req1.
   logic             prio;
`endif

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         grant0 = bus.req0_valid && (!bus.req1_valid || !prio);
         grant1 = bus.req1_valid && (!bus.req0_valid ||  prio);
`else
         grant0 = bus.req0_valid;
         grant1 = bus.req1_valid && !bus.req0_valid;
`endif
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   alu u_alu (
      .a      (cap_a),
      .b      (cap_b),
      .op     (cap_op),
      .result (alu_result),
      .carry  (alu_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cap_a        <= '0;
         cap_b        <= '0;
         cap_op       <= OP_ADD;
         cap_id       <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         prio         <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  cap_a  <= grant1 ? bus.req1_a  : bus.req0_a;
                  cap_b  <= grant1 ? bus.req1_b  : bus.req0_b;
                  cap_op <= grant1 ? bus.req1_op : bus.req0_op;
                  cap_id <= grant1;
                  state  <= EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                  prio   <= !grant1;
`endif
               end
            end
            EXEC: begin
               // Illegal opcodes report a zeroed result rather than whatever the alu emits.
               rsp_result_q <= op_is_legal(cap_op) ? alu_result : '0;
               rsp_carry_q  <= op_is_legal(cap_op) ? alu_carry  : 1'b0;
               rsp_err_q    <= !op_is_legal(cap_op);
               rsp_id_q     <= cap_id;
               rsp_valid_q  <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_carry  = rsp_carry_q;
   assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written corner
// sequences and randomized operations against an arithmetic reference model.
module tb_alu_arbiter;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic last_grant;

   alu_arbiter_if bus ();

   alu_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       who;
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      int         stall;
      logic [3:0] res;
      logic       carry;
      logic       err;
   } vec_t;

   vec_t vecs[10];

   // Reference ALU in plain integer arithmetic, returned as {err, carry, result}.
   function automatic logic [5:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
      int ia;
      int ib;
      int s;
      ia = int'(a);
      ib = int'(b);
      case (op)
         3'd0: begin s = ia + ib; return {1'b0, s > 15, 4'(s % 16)}; end
         3'd1: begin s = ia - ib; return {1'b0, s < 0, 4'((s + 16) % 16)}; end
         3'd2: return {2'b00, a & b};
         3'd3: return {2'b00, a | b};
         3'd4: return {2'b00, 4'(15 - ia)};
         default: return 6'b100000;
      endcase
   endfunction

   // Policy: a lone requester wins; on a tie round robin alternates, fixed favours req0.
   function automatic logic model_grant(input logic v0, input logic v1);
      if (v0 && v1) return RR ? !last_grant : 1'b0;
      return v1;
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
      checkOutput("reset_rsp_id", bus.rsp_id, 0);
      checkOutput("reset_rsp_result", bus.rsp_result, 0);
      checkOutput("reset_carry_err", {bus.rsp_carry, bus.rsp_err}, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      last_grant = 1'b1;
   endtask

   // One full operation: present request, handshake, check EXEC/RESP behaviour,
   // hold for 'stall' extra cycles, then accept the response.
   task automatic applyStimulus(input logic v0, input logic v1,
                                input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] op0,
                                input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] op1,
                                input int stall, input logic exp_id, input logic [3:0] exp_res,
                                input logic exp_c, input logic exp_e);
      int waited;
      @(negedge clk);
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
      bus.rsp_ready  = 1'b0;
      #1;
      waited = 0;
      while (!(bus.req0_ready || bus.req1_ready) && waited < 8) begin
         @(negedge clk);
         #1;
         waited++;
      end
      checkOutput("grant_wait", 8'(waited), 0);
      checkOutput("grant_readys", {bus.req1_ready, bus.req0_ready}, exp_id ? 8'd2 : 8'd1);
      last_grant = exp_id;
      @(posedge clk);
      #1;
      // Operands change after the handshake while valids stay high.
      bus.req0_a = ~a0; bus.req0_b = ~b0; bus.req0_op = ~op0;
      bus.req1_a = ~a1; bus.req1_b = ~b1; bus.req1_op = ~op1;
      @(negedge clk);
      checkOutput("exec_rsp_valid", bus.rsp_valid, 0);
      checkOutput("exec_readys", {bus.req1_ready, bus.req0_ready}, 0);
      @(negedge clk);
      checkOutput("rsp_valid", bus.rsp_valid, 1);
      checkOutput("rsp_id", bus.rsp_id, exp_id);
      checkOutput("rsp_result", bus.rsp_result, exp_res);
      checkOutput("rsp_carry_err", {bus.rsp_carry, bus.rsp_err}, {exp_c, exp_e});
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", bus.rsp_valid, 1);
         checkOutput("hold_result", {bus.rsp_err, bus.rsp_carry, bus.rsp_result},
                     {exp_e, exp_c, exp_res});
         checkOutput("hold_readys", {bus.req1_ready, bus.req0_ready}, 0);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      checkOutput("rsp_cleared", bus.rsp_valid, 0);
      checkOutput("idle_no_grant", {bus.req1_ready, bus.req0_ready}, 0);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [5:0] r;
      logic       v0;
      logic       v1;
      logic       gid;
      logic [3:0] ra0, rb0, ra1, rb1;
      logic [2:0] rop0, rop1;

      checks = 0;
      errors = 0;
      last_grant = 1'b1;
      rst_n = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      bus.rsp_ready  = 1'b0;

      vecs[0] = '{1'b0, 4'b1100, 4'b1011, 3'b000, 0, 4'b0111, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 4'b0111, 4'b0000, 3'b100, 5, 4'b1000, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 4'b0101, 4'b0011, 3'b110, 0, 4'b0000, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 4'b0011, 4'b0101, 3'b001, 1, 4'b1110, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 4'b1001, 4'b0100, 3'b001, 0, 4'b0101, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 4'b1010, 4'b0110, 3'b010, 2, 4'b0010, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 4'b1010, 4'b0101, 3'b011, 0, 4'b1111, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 4'b1111, 4'b1111, 3'b111, 0, 4'b0000, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 4'b1111, 4'b0001, 3'b000, 0, 4'b0000, 1'b1, 1'b0};
      vecs[9] = '{1'b1, 4'b0111, 4'b0001, 3'b000, 0, 4'b1000, 1'b0, 1'b0};

      doReset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(!vecs[i].who, vecs[i].who,
                       vecs[i].a, vecs[i].b, vecs[i].op,
                       vecs[i].a, vecs[i].b, vecs[i].op,
                       vecs[i].stall, vecs[i].who, vecs[i].res, vecs[i].carry, vecs[i].err);
      end

      $display("[TB] tie sequence, round robin = %0d", RR);
      doReset();
      for (int i = 0; i < 4; i++) begin
         gid = RR ? 1'(i % 2) : 1'b0;
         applyStimulus(1'b1, 1'b1, 4'b0101, 4'b1111, 3'b010, 4'b0110, 4'b0111, 3'b011,
                       0, gid, gid ? 4'b0111 : 4'b0101, 1'b0, 1'b0);
      end

      $display("[TB] reset during EXEC");
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_a = 4'b0001; bus.req0_b = 4'b0001; bus.req0_op = 3'b000;
      @(posedge clk);
      #1 bus.req0_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      last_grant = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("post_reset_no_rsp", bus.rsp_valid, 0);
      end
      applyStimulus(1'b0, 1'b1, 4'b0, 4'b0, 3'b0, 4'b0110, 4'b0011, 3'b001,
                    0, 1'b1, 4'b0011, 1'b0, 1'b0);

      $display("[TB] operands changing while stalled, valid dropped before grant");
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_a = 4'b0001; bus.req0_b = 4'b0010; bus.req0_op = 3'b000;
      bus.rsp_ready  = 1'b0;
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_a = 4'b0001; bus.req1_b = 4'b0001; bus.req1_op = 3'b000;
      @(negedge clk);
      checkOutput("stall_req1_ready_exec", bus.req1_ready, 0);
      bus.req1_a = 4'b1001; bus.req1_b = 4'b0011; bus.req1_op = 3'b001;
      @(negedge clk);
      checkOutput("stall_first_result", {bus.rsp_valid, bus.rsp_id, bus.rsp_result}, 6'b100011);
      bus.req1_a = 4'b1110; bus.req1_b = 4'b0101; bus.req1_op = 3'b011;
      bus.req0_valid = 1'b1;
      #2;
      checkOutput("stall_readys_resp", {bus.req1_ready, bus.req0_ready}, 0);
      bus.req0_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      checkOutput("dropped_req0_not_granted", {bus.req1_ready, bus.req0_ready}, 2);
      @(posedge clk);
      #1 bus.req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("late_operands_result",
                  {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_carry, bus.rsp_result},
                  8'b11001111);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      last_grant = 1'b1;

      $display("[TB] randomized operations");
      for (int k = 0; k < 60; k++) begin
         {v1, v0} = 2'($urandom_range(1, 3));
         ra0 = 4'($urandom); rb0 = 4'($urandom); rop0 = 3'($urandom_range(0, 7));
         ra1 = 4'($urandom); rb1 = 4'($urandom); rop1 = 3'($urandom_range(0, 7));
         gid = model_grant(v0, v1);
         r = gid ? ref_alu(ra1, rb1, rop1) : ref_alu(ra0, rb0, rop0);
         applyStimulus(v0, v1, ra0, rb0, rop0, ra1, rb1, rop1,
                       $urandom_range(0, 3), gid, r[3:0], r[4], r[5]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
